// File: rtl/pc_unit.sv
// Program counter for the RISC-V fetch stage: selects the next fetch address from
// sequential increment, branch/jump redirect, trap entry or trap return.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     INC_BYTES    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] epc_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [1:0]      state_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            flush_q, flush_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] pc_plus;
  logic            fetch_valid;

  // Wraps modulo 2^XLEN by construction of the XLEN-bit sum.
  assign pc_plus     = pc_q + XLEN'(INC_BYTES);
  assign fetch_valid = (state_q == ST_RUN);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    flush_d    = 1'b0;
    misalign_d = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_RUN;

      ST_RUN: begin
        if (trap_i) begin
          pc_d    = TRAP_VECTOR;
          epc_d   = trap_pc_i;
          flush_d = 1'b1;
        end else if (mret_i) begin
          pc_d    = epc_q;
          flush_d = 1'b1;
        end else if (redirect_i && (redirect_target_i[1:0] == 2'b00)) begin
          pc_d    = redirect_target_i;
          flush_d = 1'b1;
        end else if (redirect_i) begin
          pc_d       = TRAP_VECTOR;
          epc_d      = pc_q;
          flush_d    = 1'b1;
          misalign_d = 1'b1;
        end else if (stall_i || (fetch_valid && !fetch_ready_i)) begin
          pc_d = pc_q;
        end else begin
          pc_d = pc_plus;
        end

        // Halt only once the outstanding fetch has been accepted.
        if (halt_i && fetch_ready_i) begin
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        if (trap_i) begin
          pc_d    = TRAP_VECTOR;
          epc_d   = trap_pc_i;
          flush_d = 1'b1;
          state_d = ST_RUN;
        end else if (resume_i) begin
          state_d = ST_RUN;
        end
      end

      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc_plus_o     = pc_plus;
  assign fetch_valid_o = fetch_valid;
  assign epc_o         = epc_q;
  assign flush_o       = flush_q;
  assign misalign_o    = misalign_q;
  assign state_o       = state_q;

endmodule
